fetch_sequencer: RTL and testbench

//   Instruction-fetch controller for the 16x9 program memory. Owns the PC, drives the memory's

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_perf_cnt.sv | 42 ++++
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// FETCH_PERF_EN (when defined) enables the saturating fetch/stall counters.
package fetch_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int INSTR_W_DEF = 9;
  localparam logic [8:0] HALT_INSTR_DEF = 9'h1FF;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Ready/valid IF/ID handshake between the fetch sequencer (master) and decode (slave).
interface fetch_sequencer_if import fetch_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;

  modport master (
    output if_valid,
    output if_instr,
    output if_pc,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output if_ready
  );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch and stall event counters; cleared by reset or an accepted start.
module fetch_perf_cnt import fetch_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             fetch_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [CNT_W-1:0] fetch_q, fetch_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Next counter values: clear has priority over increments.
  always_comb begin
    fetch_d = fetch_q;
    stall_d = stall_q;
    if (clr) begin
      fetch_d = {CNT_W{1'b0}};
      stall_d = {CNT_W{1'b0}};
    end else begin
      fetch_d = fetch_inc ? sat_inc(fetch_q) : fetch_q;
      stall_d = stall_inc ? sat_inc(stall_q) : stall_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q <= {CNT_W{1'b0}};
      stall_q <= {CNT_W{1'b0}};
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads program memory and fills the IF/ID register.
// Define FETCH_PERF_EN to add the fetch_cnt/stall_cnt performance counter ports.
module fetch_sequencer import fetch_pkg::*; #(
  parameter int                  ADDR_W     = ADDR_W_DEF,
  parameter int                  INSTR_W    = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]   RESET_PC   = {ADDR_W{1'b0}},
  parameter logic [INSTR_W-1:0]  HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  pmem_addr,
  input  logic [INSTR_W-1:0] pmem_instr,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  fetch_sequencer_if.master  dec,
  output logic               busy,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic               slot_free;

  // The stage register can take a new word when empty or being drained this cycle.
  assign slot_free = !valid_q || dec.if_ready;

  // Next-state, PC and stage-register update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    case (state_q)
      ST_IDLE: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Halt beats branch; a word already presented stays until decode takes it.
        if (halt_req) begin
          state_d = ST_HALT;
          valid_d = valid_q && !dec.if_ready;
        end else if (br_taken) begin
          pc_d    = br_target;
          valid_d = 1'b0;
        end else if (slot_free) begin
          instr_d = pmem_instr;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          if (pmem_instr == HALT_INSTR) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          valid_d = valid_q;
        end
      end
      ST_HALT: begin
        if (valid_q) begin
          valid_d = !dec.if_ready;
        end else if (start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d   = (state_d == ST_RUN) || valid_d;
    halted_d = (state_d == ST_HALT);
  end

  // State, PC and IF/ID stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= {INSTR_W{1'b0}};
      ipc_q    <= {ADDR_W{1'b0}};
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign pmem_addr    = pc_q;
  assign dec.if_valid = valid_q;
  assign dec.if_instr = instr_q;
  assign dec.if_pc    = ipc_q;
  assign busy         = busy_q;
  assign halted       = halted_q;

`ifdef FETCH_PERF_EN
  logic perf_load, perf_start, perf_stall;

  assign perf_load  = (state_q == ST_RUN) && !halt_req && !br_taken && slot_free;
  assign perf_start = start && (((state_q == ST_IDLE) && !halt_req) ||
                                ((state_q == ST_HALT) && !valid_q));
  assign perf_stall = (state_q == ST_RUN) && valid_q && !dec.if_ready;

  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .clr       (perf_start),
    .fetch_inc (perf_load),
    .stall_inc (perf_stall),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random traffic vs a behavioural model.
module tb_fetch_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       halt_req;
  logic [3:0] pmem_addr;
  logic [8:0] pmem_instr;
  logic       br_taken;
  logic [3:0] br_target;
  logic       busy;
  logic       halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
`endif

  logic [8:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integers, one field per observable quantity)
  int m_mode, m_pc, m_val, m_ins, m_ipc, m_fetch, m_stall;

  fetch_sequencer_if dec_if ();

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .pmem_addr  (pmem_addr),
    .pmem_instr (pmem_instr),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .dec        (dec_if),
    .busy       (busy),
    .halted     (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  assign pmem_instr = mem[pmem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_val = 0; m_ins = 0; m_ipc = 0; m_fetch = 0; m_stall = 0;
  endtask

  // Apply one clock edge of the fetch rules to the model, using the inputs held before the edge.
  task automatic model_edge();
    int  old_mode;
    bit  taken, go, fetch, redirect;
    if (rst) begin
      model_reset();
      return;
    end
    old_mode = m_mode;
    taken    = (m_val != 0) && dec_if.if_ready;
    go       = start && ((old_mode == M_IDLE && !halt_req) || (old_mode == M_HALT && m_val == 0));
    redirect = (old_mode == M_RUN) && !halt_req && br_taken;
    fetch    = (old_mode == M_RUN) && !halt_req && !br_taken && (m_val == 0 || dec_if.if_ready);
    if (old_mode == M_RUN && m_val != 0 && !dec_if.if_ready && m_stall < 65535) m_stall++;
    if (fetch && m_fetch < 65535) m_fetch++;
    if (go) begin m_fetch = 0; m_stall = 0; end
    if (taken) m_val = 0;
    if (redirect) begin m_val = 0; m_pc = br_target; end
    if (fetch) begin
      m_ins = mem[m_pc];
      m_ipc = m_pc;
      m_val = 1;
      if (m_ins == 9'h1FF) m_mode = M_HALT;
      else m_pc = (m_pc + 1) % 16;
    end
    if (old_mode == M_IDLE && halt_req) m_mode = M_HALT;
    else if (go) begin m_mode = M_RUN; m_pc = 0; end
    else if (old_mode == M_RUN && halt_req) m_mode = M_HALT;
  endtask

  task automatic compare_all();
    check("pmem_addr", pmem_addr, m_pc);
    check("if_valid", dec_if.if_valid, m_val);
    check("if_instr", dec_if.if_instr, m_ins);
    check("if_pc", dec_if.if_pc, m_ipc);
    check("busy", busy, (m_mode == M_RUN || m_val != 0));
    check("halted", halted, (m_mode == M_HALT));
`ifdef FETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  // One clock: model steps on the rising edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; br_taken = 1'b0; br_target = 4'd0;
    dec_if.if_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 9'(i);
    mem[15] = 9'h1FF;
    model_reset();
    step();
    step();
    check("rst_pmem_addr", pmem_addr, 32'd0);
    check("rst_if_valid", dec_if.if_valid, 32'd0);
    check("rst_if_instr", dec_if.if_instr, 32'd0);
    check("rst_if_pc", dec_if.if_pc, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_halted", halted, 32'd0);
    rst = 1'b0;
    step();

    // Straight-line run to the halt word
    dec_if.if_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("s1_first_empty", dec_if.if_valid, 32'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      check("s1_if_pc", dec_if.if_pc, k);
      check("s1_if_instr", dec_if.if_instr, (k == 15) ? 32'h1FF : k);
    end
    check("s1_halted", halted, 32'd1);
    check("s1_pc_held", pmem_addr, 32'd15);
    step();
    check("s1_drained", dec_if.if_valid, 32'd0);
    check("s1_pc_still", pmem_addr, 32'd15);

    // Decode stall at if_pc=4
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("s2_at4", dec_if.if_pc, 32'd4);
    dec_if.if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("s2_hold_pc", dec_if.if_pc, 32'd4);
      check("s2_hold_addr", pmem_addr, 32'd5);
    end
    dec_if.if_ready = 1'b1;
    step();
    check("s2_next", dec_if.if_pc, 32'd5);
`ifdef FETCH_PERF_EN
    check("s2_stall_cnt", stall_cnt, 32'd3);
`endif
    step();
    check("s3_at6", dec_if.if_pc, 32'd6);

    // Branch redirect squashes the presented word
    br_taken = 1'b1; br_target = 4'd2;
    step();
    br_taken = 1'b0;
    check("s3_squash", dec_if.if_valid, 32'd0);
    check("s3_addr", pmem_addr, 32'd2);
    step();
    check("s3_tgt", dec_if.if_pc, 32'd2);
    step();
    check("s3_tgt1", dec_if.if_pc, 32'd3);

    // Halt and branch together while decode is stalled
    dec_if.if_ready = 1'b0; halt_req = 1'b1; br_taken = 1'b1; br_target = 4'd9;
    step();
    halt_req = 1'b0; br_taken = 1'b0;
    check("s4_halted", halted, 32'd1);
    check("s4_no_redirect", pmem_addr, 32'd4);
    check("s4_held_valid", dec_if.if_valid, 32'd1);
    check("s4_held_pc", dec_if.if_pc, 32'd3);
    step();
    check("s4_still_held", dec_if.if_valid, 32'd1);
    dec_if.if_ready = 1'b1;
    step();
    check("s4_delivered", dec_if.if_valid, 32'd0);
    check("s4_not_busy", busy, 32'd0);
    step();
    check("s4_no_dup", dec_if.if_valid, 32'd0);

    // PC wrap with no halt word
    for (int i = 0; i < 16; i++) mem[i] = 9'h000;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("s5_wrap_pc", dec_if.if_pc, k % 16);
    end
`ifdef FETCH_PERF_EN
    check("s5_fetch_cnt", fetch_cnt, 32'd20);
`endif

    // Asynchronous reset mid-run
    rst = 1'b1;
    #1;
    check("s6_valid", dec_if.if_valid, 32'd0);
    check("s6_addr", pmem_addr, 32'd0);
    check("s6_halted", halted, 32'd0);
    check("s6_busy", busy, 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("s6_restart_pc", dec_if.if_pc, 32'd0);
    check("s6_restart_valid", dec_if.if_valid, 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) begin
        for (int i = 0; i < 16; i++)
          mem[i] = ($urandom_range(0, 9) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
      end
      rst             = ($urandom_range(0, 199) == 0);
      start           = ($urandom_range(0, 5) == 0);
      halt_req        = ($urandom_range(0, 31) == 0);
      br_taken        = ($urandom_range(0, 7) == 0);
      br_target       = 4'($urandom_range(0, 15));
      dec_if.if_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
